// File: rtl/mem_slave_pkg.sv
// Shared types and helpers for the word-addressed slave RAM.
package mem_slave_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int ERR_CNT_W = 8;

  // Byte address is usable only if word-aligned and inside the DEPTH-word window.
  function automatic logic addr_ok(input logic [63:0] addr, input int depth);
    logic [63:0] limit;
    limit = 64'(depth) << 2;
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/mem_slave_ram_if.sv
// Memory bus between a master and the slave RAM: one read port, one write strobe.
interface mem_slave_ram_if #(
  parameter int BUSWIDTH  = 32,
  parameter int ADDRWIDTH = 32
);
  logic [ADDRWIDTH-1:0] rd_addr;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [BUSWIDTH-1:0]  wr_data;
  logic                 wren;
  logic [BUSWIDTH-1:0]  rd_data;

  modport master (output rd_addr, wr_addr, wr_data, wren, input rd_data);
  modport slave  (input rd_addr, wr_addr, wr_data, wren, output rd_data);
endinterface

// File: rtl/mem_array_1r1w.sv
// Plain storage: one synchronous write port, one asynchronous read port, no reset.
module mem_array_1r1w #(
  parameter int W     = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_slave_ram.sv
// Slave RAM with post-reset zeroing sweep, write-first read forwarding,
// access checking and a saturating error counter.
module mem_slave_ram
  import mem_slave_pkg::*;
#(
  parameter int BUSWIDTH  = 32,
  parameter int ADDRWIDTH = 32,
  parameter int DEPTH     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_slave_ram_if.slave       bus,
  output logic                 busy,
  output logic                 acc_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_q, clr_d;
  logic [BUSWIDTH-1:0]   rd_data_q, rd_data_d;
  logic                  acc_err_q, acc_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic                  rd_ok, wr_ok, wr_hit;
  logic [AW-1:0]         rd_idx, wr_idx;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [BUSWIDTH-1:0]   mem_wdata, mem_rdata;
  logic [1:0]            n_err;
  logic [ERR_CNT_W:0]    err_sum;

  assign rd_ok  = addr_ok(64'(bus.rd_addr), DEPTH);
  assign wr_ok  = addr_ok(64'(bus.wr_addr), DEPTH);
  assign rd_idx = bus.rd_addr[AW+1:2];
  assign wr_idx = bus.wr_addr[AW+1:2];
  assign wr_hit = bus.wren && wr_ok;

  // The sweep owns the write port during CLEAR; master writes are ignored then.
  assign mem_we    = (state_q == CLEAR) || wr_hit;
  assign mem_waddr = (state_q == CLEAR) ? clr_q : wr_idx;
  assign mem_wdata = (state_q == CLEAR) ? '0 : bus.wr_data;

  mem_array_1r1w #(.W(BUSWIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (rd_idx),
    .rdata_o (mem_rdata)
  );

  assign n_err   = {1'b0, ~rd_ok} + {1'b0, bus.wren & ~wr_ok};
  assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(n_err);

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    rd_data_d = '0;
    acc_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        if (rd_ok) rd_data_d = (wr_hit && (wr_idx == rd_idx)) ? bus.wr_data : mem_rdata;
        acc_err_d = (n_err != 2'd0);
        err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_q     <= '0;
      rd_data_q <= '0;
      acc_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      rd_data_q <= rd_data_d;
      acc_err_q <= acc_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign busy        = (state_q == CLEAR);
  assign acc_err     = acc_err_q;
  assign err_count   = err_cnt_q;
endmodule

// File: doc/mem_slave_ram.md
MEM_SLAVE_RAM -- requirements
Module: mem_slave_ram

Interface
REQ-001 Parameter BUSWIDTH, default 32, data width in bits; only 32 is supported.
REQ-002 Parameter ADDRWIDTH, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 1024, number of words; power of two, 4 to 65536.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 rd_addr  input  ADDRWIDTH  read byte address, sampled every cycle.
REQ-007 wr_addr  input  ADDRWIDTH  write byte address.
REQ-008 wr_data  input  BUSWIDTH  write data.
REQ-009 wren  input  1  write strobe, single-cycle, no handshake.
REQ-010 rd_data  output  BUSWIDTH  registered read data.
REQ-011 busy  output  1  high while the post-reset clear is in progress.
REQ-012 acc_err  output  1  one-cycle pulse flagging a misaligned or out-of-range access.
REQ-013 err_count  output  8  saturating count of erroneous accesses.
REQ-014 Port set SHALL match the slave modport of the team memory interface (plus rst_n, busy, acc_err, err_count); one clock; reset synchronous, active-low.

Function
REQ-015 Word index = addr[log2(DEPTH)+1:2]; access is misaligned if addr[1:0]!=0, out-of-range if addr >= DEPTH*4.
REQ-016 FSM states CLEAR and READY; reset enters CLEAR with clear counter 0.
REQ-017 CLEAR: one word per cycle is written to zero at counter index; counter increments; after index DEPTH-1 is written, next state is READY (CLEAR lasts exactly DEPTH cycles).
REQ-018 busy=1 in CLEAR, 0 in READY; in CLEAR wren is ignored, rd_data=0, no errors are flagged.
REQ-019 READY read: rd_data at cycle N+1 = mem[index(rd_addr at N)]; latency exactly 1 cycle; output holds between updates only if rd_addr is held.
REQ-020 READY write: wren=1 with valid wr_addr writes wr_data to mem at that edge.
REQ-021 Same-cycle read and write to the same valid word: rd_data returns the new wr_data (write-first).
REQ-022 Invalid read (misaligned or out-of-range): rd_data=0 next cycle, no storage access.
REQ-023 Invalid write: dropped, memory unchanged.
REQ-024 acc_err is asserted at cycle N+1 for any invalid read at N, or invalid write (wren=1) at N.
REQ-025 err_count increments by the number of invalid accesses at N (0, 1 or 2), saturating at 255, never wrapping.
REQ-026 Read of an address never written after reset returns 0.

Reset
REQ-027 rst_n=0 at an edge: state=CLEAR, counter=0, rd_data=0, acc_err=0, err_count=0, busy=1 from the next cycle.
REQ-028 Reset asserted mid-CLEAR restarts the clear from index 0; reset in READY discards all contents (full re-clear).
REQ-029 Storage array itself has no reset; zeroing is done only by the CLEAR sweep.

Structure
REQ-030 Package mem_slave_pkg holds the state enum (CLEAR, READY), the ERR_CNT_W=8 constant and the address-check helper function.
REQ-031 Storage is a sub-module mem_array_1r1w: one sync write port, one async read port, no reset; all control, forwarding and error logic lives in mem_slave_ram.

Verification
REQ-032 Reset with DEPTH=16 -> busy high for exactly 16 cycles, then low; rd_addr=0x3C read gives 0.
REQ-033 Write 0xDEADBEEF to 0x8, read 0x8 next cycle -> rd_data=0xDEADBEEF one cycle after the read address.
REQ-034 Same cycle: wren=1, wr_addr=rd_addr=0x4, wr_data=0x12345678 -> rd_data=0x12345678 next cycle.
REQ-035 Read 0x6 and write 0x40 (DEPTH=16) in the same cycle -> acc_err pulse one cycle, err_count +2, rd_data=0, memory unchanged.
REQ-036 300 invalid writes -> err_count saturates at 255.
REQ-037 Write data, reset mid-CLEAR at cycle 5 -> busy lasts DEPTH cycles after the second reset; all words read 0.
